// File: rtl/crc8_frame_checker.sv
// -----------------------------------------------------------------------------
// crc8_frame_checker
//
// Receives decoded symbols from an upstream 10b/8b decoder and checks frames
// of the form:
//   SOF (K 8'hBC), PAYLOAD_BYTES data bytes, one CRC-8 byte, EOF (K 8'h3C)
// A well-formed frame with a matching CRC is published on frame_data together
// with a one-cycle frame_valid pulse, and frame_count is incremented.
// A CRC mismatch pulses crc_err. Framing and code violations pulse frame_err.
// All three pulses appear in the cycle after the deciding symbol is sampled.
//
// Build option:
//   CRC8_CHECK_EN  defined   : the CRC byte is compared against the running
//                              CRC-8 (POLYNOMIAL, MSB-first, seeded with
//                              CRC_INIT at every SOF).
//                  undefined : the CRC byte is consumed unchecked, crc_err is
//                              tied low and the CRC register is not built.
//
// Parameters:
//   POLYNOMIAL     CRC-8 generator, implicit x^8 term
//   CRC_INIT       CRC register seed at each SOF
//   PAYLOAD_BYTES  data bytes per frame, 1..8
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   sym_valid     symbol strobe; the other sym_* inputs are ignored when low
//   sym_data      decoded byte
//   sym_k         high for a control (K) character
//   sym_code_err  invalid 10b code or running-disparity error
//   frame_data    last good payload, first byte in the MSBs
//   frame_valid   one-cycle pulse, new good frame on frame_data
//   crc_err       one-cycle pulse, CRC mismatch
//   frame_err     one-cycle pulse, framing or code violation
//   frame_count   good-frame counter, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module crc8_frame_checker #(
  parameter logic [7:0] POLYNOMIAL    = 8'h07,
  parameter logic [7:0] CRC_INIT      = 8'h00,
  parameter int         PAYLOAD_BYTES = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sym_valid,
  input  logic [7:0]                   sym_data,
  input  logic                         sym_k,
  input  logic                         sym_code_err,
  output logic [8*PAYLOAD_BYTES-1:0]   frame_data,
  output logic                         frame_valid,
  output logic                         crc_err,
  output logic                         frame_err,
  output logic [15:0]                  frame_count
);

  localparam int DW    = 8 * PAYLOAD_BYTES;
  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  localparam logic [7:0] SOF_CHAR = 8'hBC;
  localparam logic [7:0] EOF_CHAR = 8'h3C;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CRC     = 2'd2;
  localparam logic [1:0] ST_EOF     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    buf_q, buf_d;
  logic [DW-1:0]    frame_data_q, frame_data_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             crc_err_d;

  // Strobes from the frame FSM to the CRC datapath.
  logic             start_frame;
  logic             payload_byte;
  logic             crc_byte;
  logic             crc_ok;

  logic             is_sof;
  logic             is_eof;

  assign is_sof = sym_k && (sym_data == SOF_CHAR);
  assign is_eof = sym_k && (sym_data == EOF_CHAR);

  // ---------------------------------------------------------------------------
  // Frame FSM and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    int sel;
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    frame_data_d  = frame_data_q;
    frame_count_d = frame_count_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    crc_err_d     = 1'b0;
    start_frame   = 1'b0;
    payload_byte  = 1'b0;
    crc_byte      = 1'b0;
    sel           = PAYLOAD_BYTES - 1 - int'(idx_q);

    if (sym_valid) begin
      if (sym_code_err) begin
        // A corrupted symbol outranks everything else; while hunting there is
        // no frame to abort, so it is simply dropped.
        if (state_q != ST_HUNT) begin
          frame_err_d = 1'b1;
          state_d     = ST_HUNT;
        end
      end else begin
        unique case (state_q)
          ST_HUNT: begin
            start_frame = is_sof;
          end

          ST_PAYLOAD: begin
            if (sym_k) begin
              frame_err_d = 1'b1;
              start_frame = is_sof;
              state_d     = ST_HUNT;
            end else begin
              payload_byte        = 1'b1;
              buf_d[8*sel +: 8]   = sym_data;
              if (idx_q == LAST_IDX) begin
                state_d = ST_CRC;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end

          ST_CRC: begin
            if (sym_k) begin
              frame_err_d = 1'b1;
              start_frame = is_sof;
              state_d     = ST_HUNT;
            end else begin
              crc_byte = 1'b1;
              state_d  = ST_EOF;
            end
          end

          ST_EOF: begin
            if (is_eof) begin
              if (crc_ok) begin
                frame_valid_d = 1'b1;
                frame_data_d  = buf_q;
                frame_count_d = frame_count_q + 16'd1;
              end else begin
                crc_err_d = 1'b1;
              end
              state_d = ST_HUNT;
            end else begin
              frame_err_d = 1'b1;
              start_frame = is_sof;
              state_d     = ST_HUNT;
            end
          end

          default: state_d = ST_HUNT;
        endcase

        // An SOF seen anywhere opens a fresh frame, overriding the HUNT exit
        // chosen above for a violating SOF.
        if (start_frame) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
        end
      end
    end
  end

  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HUNT;
      idx_q         <= '0;
      frame_data_q  <= '0;
      frame_count_q <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_data_q  <= frame_data_d;
      frame_count_q <= frame_count_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // NOTE: the payload assembly buffer is storage, not control: every byte is
  // written before the buffer can reach frame_data, so it carries no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign frame_data  = frame_data_q;
  assign frame_count = frame_count_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

  // ---------------------------------------------------------------------------
  // CRC datapath
  // ---------------------------------------------------------------------------
`ifdef CRC8_CHECK_EN
  logic [7:0] crc_q, crc_d;
  logic       pass_q, pass_d;
  logic       crc_err_q;

  // One byte of CRC-8, MSB first: xor the byte in, then eight shift steps
  // that fold the polynomial back in whenever a one falls off the top.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d  = crc_q;
    pass_d = pass_q;
    if (start_frame) begin
      crc_d = CRC_INIT;
    end else if (payload_byte) begin
      crc_d = crc8_next(crc_q, sym_data);
    end
    // The verdict is latched at the CRC byte and consumed at EOF.
    if (crc_byte) begin
      pass_d = (sym_data == crc_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q     <= CRC_INIT;
      pass_q    <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      pass_q    <= pass_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_ok  = pass_q;
  assign crc_err = crc_err_q;
`else
  // Without checking every well-formed frame is good, so the EOF path never
  // selects crc_err and the CRC strobes have no consumer.
  logic unused_crc_sink;

  assign crc_ok          = 1'b1;
  assign crc_err         = 1'b0;
  assign unused_crc_sink = ^{POLYNOMIAL, CRC_INIT, crc_byte, crc_err_d};
`endif

endmodule

// File: tb/tb_crc8_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_crc8_frame_checker
//
// Self-checking bench for crc8_frame_checker with default parameters. Each
// scenario task drives symbols and pushes the pulses it expects (kind, cycle
// and payload) onto a scoreboard; a negedge monitor pops and compares every
// pulse the DUT produces and tracks the expected frame_data/frame_count.
// Expectations follow CRC8_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_crc8_frame_checker;

  localparam int P  = 7;
  localparam int DW = 8 * P;

  typedef logic [7:0] payload_t [P];
  typedef enum logic [1:0] {EV_VALID, EV_CRC, EV_FERR} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [DW-1:0] data;
    int            cycle;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          sym_valid;
  logic [7:0]    sym_data;
  logic          sym_k;
  logic          sym_code_err;
  logic [DW-1:0] frame_data;
  logic          frame_valid;
  logic          crc_err;
  logic          frame_err;
  logic [15:0]   frame_count;

  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  exp_t          sb[$];
  logic [DW-1:0] model_data;
  logic [15:0]   model_count;

  crc8_frame_checker #(
    .POLYNOMIAL   (8'h07),
    .CRC_INIT     (8'h00),
    .PAYLOAD_BYTES(P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .sym_k       (sym_k),
    .sym_code_err(sym_code_err),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .crc_err     (crc_err),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference CRC-8: bit-serial LFSR, MSB first, poly 0x07, seed 0x00.
  function automatic logic [7:0] ref_crc(input payload_t pl);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int b = 0; b < P; b++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = r[7] ^ pl[b][i];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pack(input payload_t pl);
    logic [DW-1:0] v;
    v = '0;
    for (int b = 0; b < P; b++) v = {v[DW-9:0], pl[b]};
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      model_data  = '0;
      model_count = '0;
      checks++;
      if ({frame_valid, crc_err, frame_err} !== 3'b000 || frame_data !== '0 ||
          frame_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs: got v/c/f=%b%b%b data=%h count=%0d required all zero",
                 frame_valid, crc_err, frame_err, frame_data, frame_count);
      end
    end else begin
      if (frame_valid || crc_err || frame_err) begin
        checks++;
        if ((int'(frame_valid) + int'(crc_err) + int'(frame_err)) != 1) begin
          errors++;
          $display("FAIL pulse_exclusive: got v/c/f=%b%b%b required one-hot",
                   frame_valid, crc_err, frame_err);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got v/c/f=%b%b%b at cycle %0d required none",
                   frame_valid, crc_err, frame_err, cyc);
        end else begin
          exp_t     e;
          ev_kind_t got;
          e   = sb.pop_front();
          got = frame_valid ? EV_VALID : (crc_err ? EV_CRC : EV_FERR);
          if (got !== e.kind || cyc != e.cycle) begin
            errors++;
            $display("FAIL pulse_kind_cycle: got %s@%0d required %s@%0d",
                     got.name(), cyc, e.kind.name(), e.cycle);
          end
          if (e.kind == EV_VALID) begin
            model_data  = e.data;
            model_count = model_count + 16'd1;
          end
        end
      end
      checks++;
      if (frame_data !== model_data || frame_count !== model_count) begin
        errors++;
        $display("FAIL frame_state: got data=%h count=%0d required data=%h count=%0d",
                 frame_data, frame_count, model_data, model_count);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one symbol for one sampling edge; 'at' is the cycle in which a
  // pulse caused by this symbol must be observed.
  task automatic send(input logic k, input logic [7:0] d, input logic err,
                      output int at);
    sym_valid    = 1'b1;
    sym_k        = k;
    sym_data     = d;
    sym_code_err = err;
    @(posedge clk);
    #1;
    at           = cyc;
    sym_valid    = 1'b0;
    sym_k        = 1'b0;
    sym_data     = 8'h00;
    sym_code_err = 1'b0;
  endtask

  task automatic expect_ev(input ev_kind_t kind, input logic [DW-1:0] data,
                           input int at);
    exp_t e;
    e.kind  = kind;
    e.data  = data;
    e.cycle = at;
    sb.push_back(e);
  endtask

  task automatic send_frame(input payload_t pl, input logic [7:0] crc,
                            input int gap, output int eof_at);
    int at;
    send(1'b1, 8'hBC, 1'b0, at);
    if (gap > 0) idle(gap);
    for (int b = 0; b < P; b++) begin
      send(1'b0, pl[b], 1'b0, at);
      if (gap > 0) idle(gap);
    end
    send(1'b0, crc, 1'b0, at);
    if (gap > 0) idle(gap);
    send(1'b1, 8'h3C, 1'b0, eof_at);
  endtask

  // Good frame expected with valid; bad-CRC frame follows the build option.
  task automatic expect_crc_frame(input payload_t pl, input logic crc_good,
                                  input int at);
`ifdef CRC8_CHECK_EN
    if (crc_good) expect_ev(EV_VALID, pack(pl), at);
    else          expect_ev(EV_CRC, '0, at);
`else
    expect_ev(EV_VALID, pack(pl), at);
`endif
  endtask

  task automatic drain(input string name);
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pulses outstanding required 0", name, sb.size());
      sb.delete();
    end
  endtask

  function automatic payload_t rand_payload();
    payload_t pl;
    for (int b = 0; b < P; b++) pl[b] = 8'($urandom_range(0, 255));
    return pl;
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    checks++;
    if (frame_valid !== 1'b0 || frame_count !== 16'd0 || frame_data !== '0) begin
      errors++;
      $display("FAIL test_reset: got v=%b count=%0d data=%h required 0/0/0",
               frame_valid, frame_count, frame_data);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    payload_t pl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    int at;
    send_frame(pl, 8'h07, 0, at);
    expect_ev(EV_VALID, 56'h00000000000001, at);
    drain("good_frame");
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL good_frame_count: got %0d required 1", frame_count);
    end
  endtask

  task automatic test_bad_crc();
    payload_t pl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    int at;
    send_frame(pl, 8'h06, 0, at);
    expect_crc_frame(pl, 1'b0, at);
    drain("bad_crc");
  endtask

  task automatic test_sof_restart();
    payload_t pl = '{default: 8'h00};
    int at;
    send(1'b1, 8'hBC, 1'b0, at);
    for (int b = 0; b < 3; b++) send(1'b0, 8'h00, 1'b0, at);
    send(1'b1, 8'hBC, 1'b0, at);
    expect_ev(EV_FERR, '0, at);
    for (int b = 0; b < P; b++) send(1'b0, 8'h00, 1'b0, at);
    send(1'b0, 8'h00, 1'b0, at);
    send(1'b1, 8'h3C, 1'b0, at);
    expect_ev(EV_VALID, pack(pl), at);
    drain("sof_restart");
  endtask

  task automatic test_stall();
    payload_t pl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    int at;
    send_frame(pl, 8'h07, 5, at);
    expect_ev(EV_VALID, 56'h00000000000001, at);
    drain("stall");
  endtask

  task automatic test_code_err();
    payload_t pl;
    int at;
    send(1'b1, 8'hBC, 1'b0, at);
    for (int b = 0; b < 3; b++) send(1'b0, 8'(8'h11 * (b + 1)), 1'b0, at);
    send(1'b0, 8'h44, 1'b1, at);
    expect_ev(EV_FERR, '0, at);
    // Remainder of the aborted frame must be ignored while hunting.
    for (int b = 4; b < P; b++) send(1'b0, 8'h55, 1'b0, at);
    send(1'b0, 8'h00, 1'b0, at);
    send(1'b1, 8'h3C, 1'b0, at);
    send(1'b0, 8'h12, 1'b1, at);
    drain("code_err_abort");
    pl = rand_payload();
    send_frame(pl, ref_crc(pl), 0, at);
    expect_ev(EV_VALID, pack(pl), at);
    drain("code_err_recover");
  endtask

  task automatic test_reset_mid_frame();
    int at;
    send(1'b1, 8'hBC, 1'b0, at);
    send(1'b0, 8'hA1, 1'b0, at);
    send(1'b0, 8'hA2, 1'b0, at);
    #2 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int b = 2; b < P; b++) send(1'b0, 8'hA3, 1'b0, at);
    send(1'b0, 8'h00, 1'b0, at);
    send(1'b1, 8'h3C, 1'b0, at);
    drain("reset_mid_frame");
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_frame_count: got %0d required 0", frame_count);
    end
  endtask

  task automatic test_back_to_back();
    payload_t pl;
    int at;
    for (int n = 0; n < 4; n++) begin
      pl = rand_payload();
      send_frame(pl, ref_crc(pl), 0, at);
      expect_ev(EV_VALID, pack(pl), at);
    end
    pl = rand_payload();
    send_frame(pl, ref_crc(pl) ^ 8'h5A, 0, at);
    expect_crc_frame(pl, 1'b0, at);
    pl = rand_payload();
    send_frame(pl, ref_crc(pl), 0, at);
    expect_ev(EV_VALID, pack(pl), at);
    drain("back_to_back");
  endtask

  task automatic test_violations();
    payload_t pl;
    int at;
    // EOF arriving in the middle of the payload.
    send(1'b1, 8'hBC, 1'b0, at);
    send(1'b0, 8'h01, 1'b0, at);
    send(1'b0, 8'h02, 1'b0, at);
    send(1'b1, 8'h3C, 1'b0, at);
    expect_ev(EV_FERR, '0, at);
    // Non-SOF K character in place of the CRC byte.
    send(1'b1, 8'hBC, 1'b0, at);
    for (int b = 0; b < P; b++) send(1'b0, 8'h00, 1'b0, at);
    send(1'b1, 8'hF7, 1'b0, at);
    expect_ev(EV_FERR, '0, at);
    // Data byte where EOF belongs.
    send(1'b1, 8'hBC, 1'b0, at);
    for (int b = 0; b < P; b++) send(1'b0, 8'h00, 1'b0, at);
    send(1'b0, 8'h00, 1'b0, at);
    send(1'b0, 8'h3C, 1'b0, at);
    expect_ev(EV_FERR, '0, at);
    // SOF where EOF belongs restarts straight into a good frame.
    send(1'b1, 8'hBC, 1'b0, at);
    for (int b = 0; b < P; b++) send(1'b0, 8'hFF, 1'b0, at);
    send(1'b0, 8'h00, 1'b0, at);
    send(1'b1, 8'hBC, 1'b0, at);
    expect_ev(EV_FERR, '0, at);
    pl = rand_payload();
    for (int b = 0; b < P; b++) send(1'b0, pl[b], 1'b0, at);
    send(1'b0, ref_crc(pl), 1'b0, at);
    send(1'b1, 8'h3C, 1'b0, at);
    expect_ev(EV_VALID, pack(pl), at);
    drain("violations");
  endtask

  initial begin
    reset        = 1'b0;
    sym_valid    = 1'b0;
    sym_data     = 8'h00;
    sym_k        = 1'b0;
    sym_code_err = 1'b0;
    model_data   = '0;
    model_count  = '0;
    #1;
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_sof_restart();
    test_stall();
    test_code_err();
    test_reset_mid_frame();
    test_back_to_back();
    test_violations();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc8_frame_checker.md
CRC8_FRAME_CHECKER -- requirements
Module: crc8_frame_checker

Interface
REQ-001 Parameter: POLYNOMIAL, 8'h07, CRC-8 generator polynomial (MSB-first, implicit x^8).
REQ-002 Parameter: CRC_INIT, 8'h00, CRC register value at each start-of-frame.
REQ-003 Parameter: PAYLOAD_BYTES, 7, data bytes per frame; legal range 1..8.
REQ-004 Port: clk  input  1  single clock; all state on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: sym_valid  input  1  symbol strobe from the upstream 10b/8b decoder; sym_data, sym_k and sym_code_err are sampled only when it is high.
REQ-007 Port: sym_data  input  8  decoded byte.
REQ-008 Port: sym_k  input  1  high = control (K) character.
REQ-009 Port: sym_code_err  input  1  high = invalid 10b code or disparity error.
REQ-010 Port: frame_data  output  8*PAYLOAD_BYTES  received payload; first byte in the MSBs.
REQ-011 Port: frame_valid  output  1  one-cycle pulse; a good frame is present on frame_data.
REQ-012 Port: crc_err  output  1  one-cycle pulse; the CRC check failed.
REQ-013 Port: frame_err  output  1  one-cycle pulse; framing or code violation.
REQ-014 Port: frame_count  output  16  count of good frames; wraps 16'hFFFF->0.

Function
REQ-015 Frame format SHALL be SOF (K, 8'hBC), then PAYLOAD_BYTES data bytes (non-K), then 1 CRC byte (non-K), then EOF (K, 8'h3C).
REQ-016 FSM states SHALL be HUNT, PAYLOAD, CRC, EOF; reset state HUNT.
REQ-017 HUNT: discard all symbols; on a valid SOF, load the CRC register with CRC_INIT, clear the byte index and go to PAYLOAD.
REQ-018 PAYLOAD: on each valid data byte, store it at the byte index and update the CRC bitwise over 8 bits MSB-first; after byte PAYLOAD_BYTES go to CRC.
REQ-019 CRC: on a valid data byte, compare it to the CRC register, latch pass/fail, and go to EOF.
REQ-020 EOF: on a valid EOF symbol, if the check passed, pulse frame_valid, update frame_data and increment frame_count; else pulse crc_err; either way return to HUNT.
REQ-021 Output latency SHALL be 1 clk: pulses are asserted in the cycle after the EOF symbol is sampled.
REQ-022 frame_data SHALL change only with frame_valid and SHALL hold its value otherwise.
REQ-023 sym_valid low in any state SHALL stall the FSM with no state change.
REQ-024 A K symbol in PAYLOAD or CRC, or a non-EOF symbol in EOF, SHALL pulse frame_err; if that symbol is SOF, restart the frame (state PAYLOAD, CRC reloaded), else go to HUNT.
REQ-025 sym_code_err with sym_valid, in any state except HUNT, SHALL pulse frame_err and force HUNT; sym_code_err takes priority over all other decoding.
REQ-026 frame_valid, crc_err and frame_err SHALL be mutually exclusive within a cycle.

Reset
REQ-027 While reset is low, asynchronously: state HUNT, CRC register = CRC_INIT, byte index 0, frame_data 0, frame_valid/crc_err/frame_err 0, frame_count 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no pulse; after release, the checker SHALL wait for a fresh SOF.

Configuration
REQ-029 Macro CRC8_CHECK_EN defined: CRC comparison per REQ-019/020.
REQ-030 Macro CRC8_CHECK_EN undefined: the CRC byte is consumed but not compared, crc_err is tied 0, every well-formed frame pulses frame_valid, and the CRC register logic is removed.

Verification
REQ-031 SOF, payload 00 00 00 00 00 00 01, CRC 07, EOF -> frame_valid 1 cycle after EOF, frame_data 56'h00000000000001, frame_count 1.
REQ-032 Same frame with CRC byte 06 -> crc_err pulse, no frame_valid, frame_data unchanged, frame_count unchanged (CRC8_CHECK_EN defined); frame_valid pulse (macro undefined).
REQ-033 SOF, 3 zero bytes, SOF, 7 zero bytes, CRC 00, EOF -> frame_err on the second SOF, then frame_valid with frame_data 0.
REQ-034 Good frame with sym_valid low for 5 cycles between each symbol -> identical result to REQ-031.
REQ-035 sym_code_err on payload byte 4 -> frame_err, FSM in HUNT; a following good frame -> frame_valid.
REQ-036 reset pulsed low after payload byte 2, then the rest of the frame sent -> no output pulses, frame_count 0.
